// File: rtl/rf_sequencer.sv
// Micro-sequencer that fetches 8-bit instructions from a small program ROM
// and drives the control lines of a two-read, one-write register file.
module rf_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] rom_data,
  output logic [3:0] rom_addr,
  output logic       SA,
  output logic       SB,
  output logic       DA,
  output logic       W,
  output logic       d_sel,
  output logic [3:0] imm,
  output logic [1:0] alu_op,
  output logic       busy,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_IMM,
    S_HALTED
  } state_t;

  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_ALU  = 3'b010;
  localparam logic [2:0] OP_JMP  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  state_t     state_q;
  logic [3:0] pc_q;
  logic [7:0] ir_q;
  logic       w_q;
  logic       d_sel_q;
  logic [3:0] imm_q;
  logic       busy_q;
  logic       halted_q;
  logic [3:0] pc_inc;

  assign pc_inc = pc_q + 4'd1;

  // Every output comes straight from a flop so the register file never sees
  // a decode glitch, and start has no combinational path to any output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      w_q      <= 1'b0;
      d_sel_q  <= 1'b0;
      imm_q    <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments; this default
      // makes W a one-cycle pulse unless a branch below re-asserts it.
      w_q <= 1'b0;
      case (state_q)
        S_IDLE, S_HALTED: begin
          if (start) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        S_FETCH: begin
          ir_q    <= rom_data;
          pc_q    <= pc_inc;
          d_sel_q <= (rom_data[7:5] == OP_ALU);
          w_q     <= (rom_data[7:5] == OP_ALU);
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          case (ir_q[7:5])
            OP_LOAD: begin
              // PC already points at the immediate word, so capture it now.
              imm_q   <= rom_data[3:0];
              w_q     <= 1'b1;
              state_q <= S_IMM;
            end
            OP_JMP: begin
              pc_q    <= ir_q[3:0];
              state_q <= S_FETCH;
            end
            OP_HALT: begin
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
              state_q  <= S_HALTED;
            end
            default: state_q <= S_FETCH;
          endcase
        end
        S_IMM: begin
          pc_q    <= pc_inc;
          state_q <= S_FETCH;
        end
        default: begin
          busy_q   <= 1'b0;
          halted_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign rom_addr = pc_q;
  assign DA       = ir_q[4];
  assign SA       = ir_q[3];
  assign SB       = ir_q[2];
  assign alu_op   = ir_q[1:0];
  assign W        = w_q;
  assign d_sel    = d_sel_q;
  assign imm      = imm_q;
  assign busy     = busy_q;
  assign halted   = halted_q;

endmodule
